mul_accumulator: RTL

Consumer stage on the output side of the 9x9 multi-multiplier. It accepts the registered 16-bit signed `mul` products one per cycle, accumulates KLEN of them per kernel window, and post-processes each window sum. Post-processing is arithmetic shift, optional ReLU and saturation. Finished results go into a 2-entry output buffer with a valid/ready handshake toward the pooling/writeback logic. A ready signal back-pressures the product stream.

---
 rtl/mul_accumulator_if.sv | 37 +++
 rtl/mul_accumulator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mul_accumulator_if.sv
// -----------------------------------------------------------------------------
// mul_accumulator_if
// Purpose : groups the two streaming handshakes around the accumulator:
//           the product stream coming from the multiplier and the result
//           stream going to the pooling/writeback logic.
// Handshake: a transfer happens on a rising clock edge where valid and ready
//           are both high. The sender holds data and valid stable until that
//           edge. Ready may be high without valid; it never depends on valid.
// Signals :
//   mul        product from multiplier (signed 16)   master -> slave
//   mul_valid  mul holds a product                   master -> slave
//   mul_ready  accumulator can take a product        slave  -> master
//   out_data   head-of-buffer result (signed OUT_W)  slave  -> master
//   out_valid  result buffer non-empty               slave  -> master
//   out_ready  consumer takes out_data               master -> slave
// Modports: slave = accumulator side, master = surrounding datapath/bench.
// -----------------------------------------------------------------------------
interface mul_accumulator_if #(
   parameter int OUT_W = 16
) ();
   logic [15:0]      mul;
   logic             mul_valid;
   logic             mul_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  mul, mul_valid, out_ready,
      output mul_ready, out_data, out_valid
   );

   modport master (
      output mul, mul_valid, out_ready,
      input  mul_ready, out_data, out_valid
   );
endinterface

// File: rtl/mul_accumulator.sv
// -----------------------------------------------------------------------------
// mul_accumulator
// Purpose : sums KLEN signed products per kernel window, then arithmetic
//           right-shifts, optionally ReLU-clamps and saturates the sum to
//           OUT_W bits, and queues the result in a 2-entry output FIFO.
// Ports   :
//   clk, rst_n    clock, asynchronous active-low reset
//   i_clr         synchronous window abort (counter, accumulator, sat flag)
//   i_shift       arithmetic right shift, used on the last-product cycle only
//   i_relu_en     clamp negative results to 0, last-product cycle only
//   bus           product in / result out handshakes (slave modport)
//   o_sat_flag    sticky: some result was clipped since reset/clr
//   o_win_cnt     products accepted in the current window
//   o_state       window FSM state (0 = IDLE, 1 = ACCUM)
// -----------------------------------------------------------------------------
module mul_accumulator #(
   parameter int KLEN  = 9,
   parameter int ACC_W = 24,
   parameter int OUT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_clr,
   input  logic [3:0]             i_shift,
   input  logic                   i_relu_en,
   mul_accumulator_if.slave       bus,
   output logic                   o_sat_flag,
   output logic [7:0]             o_win_cnt,
   output logic                   o_state
);

   typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     w_first;

   logic signed [ACC_W-1:0]  r_acc;
   logic [7:0]               r_win_cnt;
   logic                     r_sat_flag;

   logic [OUT_W-1:0]         r_mem [2];
   logic                     r_wr_ptr;
   logic                     r_rd_ptr;
   logic [1:0]               r_count;

   logic                     w_accept;
   logic                     w_last;
   logic                     w_push;
   logic                     w_pop;
   logic signed [ACC_W-1:0]  w_mul_ext;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_shifted;
   logic signed [ACC_W-1:0]  w_relu;
   logic                     w_sat_hi;
   logic                     w_sat_lo;
   logic [OUT_W-1:0]         w_result;

   // Ready is a decode of the registered count only, so out_ready never
   // reaches mul_ready combinationally.
   assign bus.mul_ready = (r_count != 2'd2);
   assign bus.out_valid = (r_count != 2'd0);
   assign bus.out_data  = r_mem[r_rd_ptr];

   assign w_accept = bus.mul_valid & bus.mul_ready;
   assign w_last   = w_accept & (r_win_cnt == 8'(KLEN-1));
   // clr wins over a push, so the window being finished is simply lost.
   assign w_push   = w_last & ~i_clr;
   assign w_pop    = bus.out_valid & bus.out_ready;

   // ---------------- window FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // ---------------- window FSM: next state ----------------
   // KLEN >= 2, so the first accept of a window is never also its last.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && !i_clr)  w_state_nxt = S_ACCUM;
         S_ACCUM: if (i_clr || w_last)     w_state_nxt = S_IDLE;
         default:                           w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- window FSM: outputs ----------------
   // In IDLE the accumulator holds zero, so the adder's stored operand is
   // dropped and the first product is loaded directly.
   always_comb begin
      w_first = 1'b0;
      o_state = 1'b0;
      case (r_state)
         S_IDLE:  begin w_first = 1'b1; o_state = 1'b0; end
         S_ACCUM: begin w_first = 1'b0; o_state = 1'b1; end
         default: begin w_first = 1'b1; o_state = 1'b0; end
      endcase
   end

   // ---------------- datapath ----------------
   assign w_mul_ext = {{(ACC_W-16){bus.mul[15]}}, bus.mul};
   assign w_sum     = (w_first ? '0 : r_acc) + w_mul_ext;
   assign w_shifted = w_sum >>> i_shift;
   assign w_relu    = (i_relu_en && w_shifted[ACC_W-1]) ? '0 : w_shifted;
   assign w_sat_hi  = (w_relu > SAT_MAX);
   assign w_sat_lo  = (w_relu < SAT_MIN);
   assign w_result  = w_sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                      w_sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} :
                                 w_relu[OUT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_win_cnt  <= '0;
         r_sat_flag <= 1'b0;
      end else if (i_clr) begin
         r_acc      <= '0;
         r_win_cnt  <= '0;
         r_sat_flag <= 1'b0;
      end else if (w_last) begin
         r_acc      <= '0;
         r_win_cnt  <= '0;
         r_sat_flag <= r_sat_flag | w_sat_hi | w_sat_lo;
      end else if (w_accept) begin
         r_acc      <= w_sum;
         r_win_cnt  <= r_win_cnt + 8'd1;
      end
   end

   assign o_win_cnt  = r_win_cnt;
   assign o_sat_flag = r_sat_flag;

   // ---------------- 2-entry output FIFO ----------------
   // A push never meets a full buffer: a push needs an accept, and an accept
   // needs count != 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
